lc3_writeback: RTL
==================

LC3_WRITEBACK -- requirements
Module: lc3_writeback

Interface
REQ-001 Parameter PSR_RESET, default 3'b010, is the PSR value loaded on reset (N,Z,P order).
REQ-002 clock  input  1  single rising-edge clock for all state.
REQ-003 reset_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 enable_writeback  input  1  qualifies one write per cycle from the execute stage.
REQ-005 W_Control  input  2  write source: 0=aluout, 1=memout, 2=pcout, 3=illegal.
REQ-006 aluout  input  16  execute-stage ALU result.
REQ-007 memout  input  16  memory read data.
REQ-008 pcout  input  16  execute-stage PC result.
REQ-009 dr  input  3  destination register index.
REQ-010 sr1  input  3  read port 1 index.
REQ-011 sr2  input  3  read port 2 index.
REQ-012 VSR1  output  16  value of R[sr1].
REQ-013 VSR2  output  16  value of R[sr2].
REQ-014 psr  output  3  condition codes {N,Z,P}; exactly one bit set.
REQ-015 wb_err  output  1  sticky flag; set by an illegal write request.
REQ-016 wb_count  output  16  count of committed writes.

Function
REQ-017 Eight 16-bit registers R0..R7 shall be held.
REQ-018 Write: on a rising clock with enable_writeback=1 and W_Control in 0..2, R[dr] shall load the selected source.
REQ-019 psr shall update on the same edge from the written value: N if bit15=1; Z if value=0; else P.
REQ-020 enable_writeback=0 shall leave registers, psr and wb_count unchanged.
REQ-021 enable_writeback=1 with W_Control=3 shall write nothing, leave psr unchanged and set wb_err on that edge.
REQ-022 wb_err shall clear only on reset.
REQ-023 wb_count shall increment by 1 per committed write and wrap from 16'hFFFF to 0.
REQ-024 VSR1/VSR2 shall be combinational reads of the register array; a committed write is visible from the cycle after its edge.
REQ-025 sr1=sr2 shall return the same value on both ports.
REQ-026 There shall be no ready/backpressure; every qualified request shall be accepted in its cycle.

Reset
REQ-027 reset_n low shall immediately force R0..R7=16'h0000, psr=PSR_RESET, wb_err=0, wb_count=0.
REQ-028 A write whose edge coincides with reset_n low shall be discarded.
REQ-029 The first write shall be accepted on the first rising edge after reset_n deasserts.

Configuration
REQ-030 With LC3_WB_BYPASS_EN defined, a read whose sr1/sr2 equals dr during a same-cycle legal write shall return the write data combinationally, with write-first behaviour.
REQ-031 Without LC3_WB_BYPASS_EN, same-cycle reads shall return the old register value (REQ-024 timing).

Verification
REQ-032 Reset, then read all sr1/sr2 indices -> VSR1=VSR2=0, psr=3'b010, wb_err=0, wb_count=0.
REQ-033 enable=1, W_Control=0, aluout=16'h8001, dr=3 -> next cycle R3=16'h8001, psr=3'b100, wb_count=1.
REQ-034 enable=1, W_Control=1, memout=0, dr=5, then W_Control=2, pcout=16'h3005, dr=5 -> R5 sequence 0 then 16'h3005; psr sequence 010 then 001.
REQ-035 enable=1, W_Control=3, dr=2 -> R2 unchanged, psr unchanged, wb_err=1 and held; wb_count unchanged.
REQ-036 Write R4=16'h1234 with sr1=4 in the same cycle -> VSR1=16'h1234 that cycle with LC3_WB_BYPASS_EN defined; old value without it.
REQ-037 Assert reset_n mid-stream after 16'hFFFF writes -> all state returns to REQ-027 values asynchronously; before reset, the next write wraps wb_count to 0.

Source files
------------

// File: rtl/lc3_writeback_if.sv
// Execute-to-writeback bus for the LC-3 register file: write request, read ports, status.
interface lc3_writeback_if;
    logic        enable_writeback;
    logic [1:0]  W_Control;
    logic [15:0] aluout;
    logic [15:0] memout;
    logic [15:0] pcout;
    logic [2:0]  dr;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [15:0] VSR1;
    logic [15:0] VSR2;
    logic [2:0]  psr;
    logic        wb_err;
    logic [15:0] wb_count;

    modport master (
        output enable_writeback, W_Control, aluout, memout, pcout, dr, sr1, sr2,
        input  VSR1, VSR2, psr, wb_err, wb_count
    );

    modport slave (
        input  enable_writeback, W_Control, aluout, memout, pcout, dr, sr1, sr2,
        output VSR1, VSR2, psr, wb_err, wb_count
    );
endinterface

// File: rtl/lc3_writeback.sv
// LC-3 writeback stage: 8x16 register file, NZP condition codes, error flag and write counter.
// Optional macro LC3_WB_BYPASS_EN forwards same-cycle write data onto the read ports.
module lc3_writeback #(
    parameter logic [2:0] PSR_RESET = 3'b010
) (
    input logic             clock,
    input logic             reset_n,
    lc3_writeback_if.slave  wb
);

    logic [15:0] regs_q [8];
    logic [15:0] regs_d [8];
    logic [2:0]  psr_q, psr_d;
    logic        wb_err_q, wb_err_d;
    logic [15:0] wb_count_q, wb_count_d;

    logic        wr_legal;
    logic        wr_illegal;
    logic [15:0] wr_data;
    logic [2:0]  wr_psr;

    always_comb begin
        wr_legal   = wb.enable_writeback && (wb.W_Control != 2'd3);
        wr_illegal = wb.enable_writeback && (wb.W_Control == 2'd3);

        // Source 3 never commits, so its mux leg is a don't-care.
        unique case (wb.W_Control)
            2'd0:    wr_data = wb.aluout;
            2'd1:    wr_data = wb.memout;
            2'd2:    wr_data = wb.pcout;
            default: wr_data = wb.aluout;
        endcase

        if (wr_data[15]) begin
            wr_psr = 3'b100;
        end else if (wr_data == 16'h0000) begin
            wr_psr = 3'b010;
        end else begin
            wr_psr = 3'b001;
        end
    end

    always_comb begin
        regs_d     = regs_q;
        psr_d      = psr_q;
        wb_err_d   = wb_err_q;
        wb_count_d = wb_count_q;
        if (wr_legal) begin
            regs_d[wb.dr] = wr_data;
            psr_d         = wr_psr;
            wb_count_d    = wb_count_q + 16'd1;
        end
        if (wr_illegal) begin
            wb_err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 16'h0000;
            end
            psr_q      <= PSR_RESET;
            wb_err_q   <= 1'b0;
            wb_count_q <= 16'h0000;
        end else begin
            regs_q     <= regs_d;
            psr_q      <= psr_d;
            wb_err_q   <= wb_err_d;
            wb_count_q <= wb_count_d;
        end
    end

    always_comb begin
`ifdef LC3_WB_BYPASS_EN
        // Write-first: a read of the register being written sees the new value now.
        wb.VSR1 = (wr_legal && (wb.sr1 == wb.dr)) ? wr_data : regs_q[wb.sr1];
        wb.VSR2 = (wr_legal && (wb.sr2 == wb.dr)) ? wr_data : regs_q[wb.sr2];
`else
        wb.VSR1 = regs_q[wb.sr1];
        wb.VSR2 = regs_q[wb.sr2];
`endif
        wb.psr      = psr_q;
        wb.wb_err   = wb_err_q;
        wb.wb_count = wb_count_q;
    end

endmodule
